// File: rtl/ln_backward_if.sv
// Handshake and tile bus of the layer-norm backward block (clk/reset stay plain ports).
interface ln_backward_if #(
  parameter int IL   = 4,
  parameter int FL   = 16,
  parameter int size = 8
);
  localparam int W = IL + FL;

  logic                input_ready;
  logic                output_taken;
  logic signed [W-1:0] dout [size][size];
  logic signed [W-1:0] norm [size][size];
  logic signed [W-1:0] root;
  logic signed [W-1:0] din  [size][size];
  logic [1:0]          state;
  logic                done;

  modport master (output input_ready, output_taken, dout, norm, root,
                  input  din, state, done);
  modport slave  (input  input_ready, output_taken, dout, norm, root,
                  output din, state, done);
endinterface

// File: rtl/ln_backward.sv
// Layer-norm backward pass over one size x size Q(IL.FL) tile: row accumulate, serial reciprocal, row output.
// Define LN_BACKWARD_SAT_EN to saturate final din elements; otherwise they wrap to IL+FL bits.
module ln_backward #(
  parameter int IL    = 4,
  parameter int FL    = 16,
  parameter int size  = 8,
  parameter int width = $clog2(size)
) (
  input logic          clk,
  input logic          reset,
  ln_backward_if.slave bus
);
  localparam int W  = IL + FL;
  localparam int AW = W + 2 * width;
  localparam int PW = W + IL;
  localparam int DW = PW + 2;
  localparam int FW = DW + W - FL;
  localparam int CW = $clog2(W > size ? W : size);

  localparam logic signed [W-1:0] MAX_POS  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]        REM_INIT = W'(2 ** (FL - IL));

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;
  typedef enum logic [1:0] {PH_ACC, PH_DIV, PH_OUT} phase_t;

  state_t               state_q, next_state;
  phase_t               phase;
  logic [CW-1:0]        cnt;
  logic [width-1:0]     row;
  logic                 last_row, last_div;
  logic signed [AW-1:0] sum_dy, sum_dxh, row_dy, row_dxh;
  logic signed [W-1:0]  mean_dy, mean_dxh, inv_std;
  logic [W-1:0]         rem, quo;
  logic [W:0]           rem_sh, root_ext;
  logic                 div_fits, ovf_init;
  logic signed [DW-1:0] diff    [size];
  logic signed [W-1:0]  out_row [size];

  function automatic logic signed [PW-1:0] mul_fl(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    return PW'(((2*W)'(a) * (2*W)'(b)) >>> FL);
  endfunction

  function automatic logic signed [FW-1:0] mul_out(input logic signed [DW-1:0] d,
                                                   input logic signed [W-1:0]  s);
    return FW'(((DW+W)'(d) * (DW+W)'(s)) >>> FL);
  endfunction

  function automatic logic signed [W-1:0] fit_out(input logic signed [FW-1:0] v);
`ifdef LN_BACKWARD_SAT_EN
    if (v > FW'(MAX_POS)) return MAX_POS;
    if (v < FW'(MIN_NEG)) return MIN_NEG;
`endif
    return W'(v);
  endfunction

  assign row      = cnt[width-1:0];
  assign last_row = (cnt == CW'(size - 1));
  assign last_div = (cnt == CW'(W - 1));
  assign mean_dy  = sum_dy[AW-1:2*width];
  assign mean_dxh = sum_dxh[AW-1:2*width];
  assign rem_sh   = {rem, 1'b0};
  assign root_ext = {1'b0, bus.root};
  assign div_fits = (rem_sh >= root_ext);
  assign bus.state = state_q;
  assign bus.done  = (state_q == DONE);

  always_comb begin
    row_dy  = '0;
    row_dxh = '0;
    for (int c = 0; c < size; c++) begin
      row_dy  = row_dy + AW'(bus.dout[row][c]);
      row_dxh = row_dxh + AW'(mul_fl(bus.dout[row][c], bus.norm[row][c]));
    end
  end

  // Non-positive root or a quotient that does not fit Q(IL.FL) both pin the reciprocal at max.
  always_comb begin
    inv_std = quo;
    if (bus.root[W-1] || (bus.root == '0) || ovf_init || quo[W-1])
      inv_std = MAX_POS;
  end

  always_comb begin
    diff    = '{default: '0};
    out_row = '{default: '0};
    for (int c = 0; c < size; c++) begin
      diff[c]    = DW'(bus.dout[row][c]) - DW'(mean_dy)
                 - DW'(mul_fl(bus.norm[row][c], mean_dxh));
      out_row[c] = fit_out(mul_out(diff[c], inv_std));
    end
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (bus.input_ready) next_state = BUSY;
      BUSY:    if (phase == PH_OUT && last_row) next_state = DONE;
      DONE:    if (bus.output_taken) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= PH_ACC;
      cnt      <= '0;
      sum_dy   <= '0;
      sum_dxh  <= '0;
      rem      <= '0;
      quo      <= '0;
      ovf_init <= 1'b0;
      for (int r = 0; r < size; r++)
        for (int c = 0; c < size; c++)
          bus.din[r][c] <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.input_ready) begin
          phase    <= PH_ACC;
          cnt      <= '0;
          sum_dy   <= '0;
          sum_dxh  <= '0;
          rem      <= REM_INIT;
          quo      <= '0;
          ovf_init <= ({1'b0, REM_INIT} >= root_ext);
        end
        BUSY: case (phase)
          PH_ACC: begin
            sum_dy  <= sum_dy + row_dy;
            sum_dxh <= sum_dxh + row_dxh;
            cnt     <= last_row ? '0 : cnt + CW'(1);
            if (last_row) phase <= PH_DIV;
          end
          PH_DIV: begin
            // One restoring-division quotient bit per cycle, MSB first.
            if (div_fits) begin
              rem <= W'(rem_sh - root_ext);
              quo <= {quo[W-2:0], 1'b1};
            end else begin
              rem <= W'(rem_sh);
              quo <= {quo[W-2:0], 1'b0};
            end
            cnt <= last_div ? '0 : cnt + CW'(1);
            if (last_div) phase <= PH_OUT;
          end
          PH_OUT: begin
            for (int c = 0; c < size; c++)
              bus.din[row][c] <= out_row[c];
            cnt <= last_row ? '0 : cnt + CW'(1);
          end
          default: phase <= PH_ACC;
        endcase
        default: ;
      endcase
    end
  end
endmodule
